// File: rtl/ch3_wave_gen.sv
// Channel 3 wave playback engine: frequency/position counters, wave RAM fetch,
// volume shift and length counter feeding the 4-bit sample to the mixer.
module ch3_wave_gen (
    input  logic        cery_2mhz,
    input  logic        napu_reset,
    input  logic        nff1a_d7,
    input  logic        ff1b_wr,
    input  logic [7:0]  ff1b_d,
    input  logic        ff1c_d5,
    input  logic        ff1c_d6,
    input  logic [7:0]  ff1d_d,
    input  logic [2:0]  ff1e_d,
    input  logic        ff1e_d6,
    input  logic        ch3_trig,
    input  logic        len_tick,
    input  logic [7:0]  wave_data,
    output logic        wave_rd,
    output logic [3:0]  wave_addr,
    output logic [10:0] freq_cnt,
    output logic        ch3_active,
    output logic [3:0]  ch3_out
);

    logic [10:0] freq;
    logic        dac_on;
    logic [1:0]  vol;

    logic [10:0] freq_cnt_q, freq_cnt_d;
    logic [4:0]  pos_q, pos_d;
    logic [4:0]  pos_inc;
    logic [3:0]  sample_nib_q, sample_nib_d;
    logic [7:0]  len_cnt_q, len_cnt_d;
    logic        len_done_q, len_done_d;
    logic        len_done_eff;
    logic        len_expire;
    logic        active_q, active_d;
    logic        rd_q, rd_d;
    logic        sel_lo_q, sel_lo_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  out_q, out_d;
    logic [3:0]  scaled;

    assign freq    = {ff1e_d, ff1d_d};
    assign dac_on  = ~nff1a_d7;
    assign vol     = {ff1c_d6, ff1c_d5};
    assign pos_inc = pos_q + 5'd1;

    // Frequency counter, wave position and fetch request; trigger wins over overflow.
    always_comb begin
        freq_cnt_d = freq_cnt_q;
        pos_d      = pos_q;
        rd_d       = 1'b0;
        addr_d     = addr_q;
        sel_lo_d   = sel_lo_q;
        if (ch3_trig) begin
            freq_cnt_d = freq;
            pos_d      = 5'd0;
        end else if (active_q && dac_on) begin
            if (freq_cnt_q == 11'h7FF) begin
                freq_cnt_d = freq;
                pos_d      = pos_inc;
                rd_d       = 1'b1;
                addr_d     = pos_inc[4:1];
                sel_lo_d   = pos_inc[0];
            end else begin
                freq_cnt_d = freq_cnt_q + 11'd1;
            end
        end
    end

    // Capture the fetched nibble the cycle after the read request; a trigger does not refetch.
    always_comb begin
        sample_nib_d = sample_nib_q;
        if (rd_q) begin
            sample_nib_d = sel_lo_q ? wave_data[3:0] : wave_data[7:4];
        end
    end

    // Length counter: a trigger clears done before a coincident tick is counted.
    always_comb begin
        len_cnt_d    = len_cnt_q;
        len_expire   = 1'b0;
        len_done_eff = ch3_trig ? 1'b0 : len_done_q;
        len_done_d   = len_done_eff;
        if (ff1b_wr) begin
            len_cnt_d  = ff1b_d;
            len_done_d = 1'b0;
        end else if (len_tick && ff1e_d6 && !len_done_eff) begin
            len_cnt_d = len_cnt_q + 8'd1;
            if (len_cnt_q == 8'hFF) begin
                len_done_d = 1'b1;
                len_expire = 1'b1;
            end
        end
    end

    // Channel active flag: DAC off beats trigger, trigger beats length expiry.
    always_comb begin
        active_d = active_q;
        if (len_expire) begin
            active_d = 1'b0;
        end
        if (ch3_trig && dac_on) begin
            active_d = 1'b1;
        end
        if (!dac_on) begin
            active_d = 1'b0;
        end
    end

    // Volume shift on the held nibble, muted when the channel or DAC is off.
    always_comb begin
        scaled = 4'd0;
        unique case (vol)
            2'd0: scaled = 4'd0;
            2'd1: scaled = sample_nib_q;
            2'd2: scaled = sample_nib_q >> 1;
            2'd3: scaled = sample_nib_q >> 2;
            default: scaled = 4'd0;
        endcase
        out_d = (active_d && dac_on) ? scaled : 4'd0;
    end

    // State registers.
    always_ff @(posedge cery_2mhz or negedge napu_reset) begin
        if (!napu_reset) begin
            freq_cnt_q   <= 11'd0;
            pos_q        <= 5'd0;
            sample_nib_q <= 4'd0;
            len_cnt_q    <= 8'd0;
            len_done_q   <= 1'b0;
            active_q     <= 1'b0;
            rd_q         <= 1'b0;
            sel_lo_q     <= 1'b0;
            addr_q       <= 4'd0;
            out_q        <= 4'd0;
        end else begin
            freq_cnt_q   <= freq_cnt_d;
            pos_q        <= pos_d;
            sample_nib_q <= sample_nib_d;
            len_cnt_q    <= len_cnt_d;
            len_done_q   <= len_done_d;
            active_q     <= active_d;
            rd_q         <= rd_d;
            sel_lo_q     <= sel_lo_d;
            addr_q       <= addr_d;
            out_q        <= out_d;
        end
    end

    assign wave_rd    = rd_q;
    assign wave_addr  = addr_q;
    assign freq_cnt   = freq_cnt_q;
    assign ch3_active = active_q;
    assign ch3_out    = out_q;

endmodule

// File: tb/tb_ch3_wave_gen.sv
// Directed bench for ch3_wave_gen: playback timing, volume, length, priorities, reset.
module tb_ch3_wave_gen;

    logic        cery_2mhz;
    logic        napu_reset;
    logic        nff1a_d7;
    logic        ff1b_wr;
    logic [7:0]  ff1b_d;
    logic        ff1c_d5;
    logic        ff1c_d6;
    logic [7:0]  ff1d_d;
    logic [2:0]  ff1e_d;
    logic        ff1e_d6;
    logic        ch3_trig;
    logic        len_tick;
    logic [7:0]  wave_data;
    logic        wave_rd;
    logic [3:0]  wave_addr;
    logic [10:0] freq_cnt;
    logic        ch3_active;
    logic [3:0]  ch3_out;

    int errors = 0;
    int checks = 0;

    ch3_wave_gen dut (
        .cery_2mhz (cery_2mhz),
        .napu_reset(napu_reset),
        .nff1a_d7  (nff1a_d7),
        .ff1b_wr   (ff1b_wr),
        .ff1b_d    (ff1b_d),
        .ff1c_d5   (ff1c_d5),
        .ff1c_d6   (ff1c_d6),
        .ff1d_d    (ff1d_d),
        .ff1e_d    (ff1e_d),
        .ff1e_d6   (ff1e_d6),
        .ch3_trig  (ch3_trig),
        .len_tick  (len_tick),
        .wave_data (wave_data),
        .wave_rd   (wave_rd),
        .wave_addr (wave_addr),
        .freq_cnt  (freq_cnt),
        .ch3_active(ch3_active),
        .ch3_out   (ch3_out)
    );

    initial cery_2mhz = 1'b0;
    always #5 cery_2mhz = ~cery_2mhz;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge cery_2mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        napu_reset = 1'b1;
        nff1a_d7   = 1'b1;
        ff1b_wr    = 1'b0;
        ff1b_d     = 8'h00;
        ff1c_d5    = 1'b0;
        ff1c_d6    = 1'b0;
        ff1d_d     = 8'h00;
        ff1e_d     = 3'h0;
        ff1e_d6    = 1'b0;
        ch3_trig   = 1'b0;
        len_tick   = 1'b0;
        wave_data  = 8'h00;

        // Power-on reset
        #2 napu_reset = 1'b0;
        #1;
        chk("rst_out", 16'(ch3_out), 16'h0);
        chk("rst_rd", 16'(wave_rd), 16'h0);
        chk("rst_addr", 16'(wave_addr), 16'h0);
        chk("rst_freq", 16'(freq_cnt), 16'h0);
        chk("rst_active", 16'(ch3_active), 16'h0);
        tick(2);
        napu_reset = 1'b1;
        tick();

        // Playback: freq 0x7FC, vol 1, wave byte 0xA5
        nff1a_d7  = 1'b0;
        ff1e_d    = 3'h7;
        ff1d_d    = 8'hFC;
        ff1c_d5   = 1'b1;
        ff1c_d6   = 1'b0;
        wave_data = 8'hA5;
        tick();
        chk("idle_inactive", 16'(ch3_active), 16'h0);
        ch3_trig = 1'b1;
        tick();
        ch3_trig = 1'b0;
        chk("trig_active", 16'(ch3_active), 16'h1);
        chk("trig_freq", 16'(freq_cnt), 16'h7FC);
        chk("trig_out_stale0", 16'(ch3_out), 16'h0);
        tick(3);
        chk("pre_ovf_freq", 16'(freq_cnt), 16'h7FF);
        chk("pre_ovf_rd", 16'(wave_rd), 16'h0);
        tick();
        chk("ovf1_freq", 16'(freq_cnt), 16'h7FC);
        chk("ovf1_rd", 16'(wave_rd), 16'h1);
        chk("ovf1_addr", 16'(wave_addr), 16'h0);
        chk("ovf1_pos", 16'(dut.pos_q), 16'h1);
        tick();
        chk("rd_single", 16'(wave_rd), 16'h0);
        tick();
        chk("out_lo_v1", 16'(ch3_out), 16'h5);
        tick(2);
        chk("ovf2_rd", 16'(wave_rd), 16'h1);
        chk("ovf2_addr", 16'(wave_addr), 16'h1);
        chk("ovf2_pos", 16'(dut.pos_q), 16'h2);
        tick(2);
        chk("out_hi_v1", 16'(ch3_out), 16'hA);

        // Volume codes
        ff1c_d6 = 1'b1; ff1c_d5 = 1'b0;
        tick();
        chk("out_hi_v2", 16'(ch3_out), 16'h5);
        ff1c_d6 = 1'b1; ff1c_d5 = 1'b1;
        tick();
        chk("out_hi_v3", 16'(ch3_out), 16'h2);
        ff1c_d6 = 1'b0; ff1c_d5 = 1'b0;
        tick();
        chk("out_v0", 16'(ch3_out), 16'h0);
        ff1c_d6 = 1'b0; ff1c_d5 = 1'b1;
        tick();
        chk("out_lo_v1b", 16'(ch3_out), 16'h5);

        // Position wrap 31 -> 0
        tick(110);
        chk("pos31", 16'(dut.pos_q), 16'd31);
        chk("addr15", 16'(wave_addr), 16'hF);
        tick(4);
        chk("pos_wrap", 16'(dut.pos_q), 16'h0);
        chk("wrap_addr", 16'(wave_addr), 16'h0);
        chk("wrap_rd", 16'(wave_rd), 16'h1);
        tick(2);
        chk("wrap_out", 16'(ch3_out), 16'hA);

        // DAC off during playback, then trigger with DAC off
        nff1a_d7 = 1'b1;
        tick();
        chk("dacoff_active", 16'(ch3_active), 16'h0);
        chk("dacoff_out", 16'(ch3_out), 16'h0);
        chk("dacoff_freq", 16'(freq_cnt), 16'h7FE);
        tick();
        chk("dacoff_frozen", 16'(freq_cnt), 16'h7FE);
        ch3_trig = 1'b1;
        tick();
        ch3_trig = 1'b0;
        chk("trig_dacoff_active", 16'(ch3_active), 16'h0);
        chk("trig_dacoff_freq", 16'(freq_cnt), 16'h7FC);
        chk("trig_dacoff_pos", 16'(dut.pos_q), 16'h0);

        // Retrigger plays stale nibble; trigger beats overflow
        nff1a_d7 = 1'b0;
        tick();
        ch3_trig = 1'b1;
        tick();
        ch3_trig = 1'b0;
        chk("retrig_active", 16'(ch3_active), 16'h1);
        chk("retrig_stale_out", 16'(ch3_out), 16'hA);
        tick(3);
        chk("coinc_pre_freq", 16'(freq_cnt), 16'h7FF);
        ch3_trig = 1'b1;
        tick();
        ch3_trig = 1'b0;
        chk("coinc_freq", 16'(freq_cnt), 16'h7FC);
        chk("coinc_pos", 16'(dut.pos_q), 16'h0);
        chk("coinc_no_rd", 16'(wave_rd), 16'h0);

        // Length counter
        ff1b_d  = 8'hFE;
        ff1b_wr = 1'b1;
        tick();
        ff1b_wr = 1'b0;
        chk("len_load", 16'(dut.len_cnt_q), 16'hFE);
        ff1e_d6  = 1'b0;
        len_tick = 1'b1;
        tick();
        len_tick = 1'b0;
        chk("len_disabled", 16'(dut.len_cnt_q), 16'hFE);
        ff1e_d6  = 1'b1;
        len_tick = 1'b1;
        tick();
        chk("len_ff", 16'(dut.len_cnt_q), 16'hFF);
        chk("len_ff_active", 16'(ch3_active), 16'h1);
        tick();
        len_tick = 1'b0;
        chk("len_exp_cnt", 16'(dut.len_cnt_q), 16'h00);
        chk("len_exp_active", 16'(ch3_active), 16'h0);
        chk("len_exp_out", 16'(ch3_out), 16'h0);
        ch3_trig = 1'b1;
        tick();
        ch3_trig = 1'b0;
        chk("len_retrig_active", 16'(ch3_active), 16'h1);
        len_tick = 1'b1;
        tick(255);
        chk("len255_cnt", 16'(dut.len_cnt_q), 16'hFF);
        chk("len255_active", 16'(ch3_active), 16'h1);
        tick();
        len_tick = 1'b0;
        chk("len256_cnt", 16'(dut.len_cnt_q), 16'h00);
        chk("len256_active", 16'(ch3_active), 16'h0);

        // Coincident trigger / write / tick
        ch3_trig = 1'b1;
        len_tick = 1'b1;
        tick();
        ch3_trig = 1'b0;
        chk("trig_tick_cnt", 16'(dut.len_cnt_q), 16'h01);
        chk("trig_tick_active", 16'(ch3_active), 16'h1);
        ff1b_d  = 8'hFF;
        ff1b_wr = 1'b1;
        tick();
        ff1b_wr = 1'b0;
        chk("wr_beats_tick", 16'(dut.len_cnt_q), 16'hFF);
        ch3_trig = 1'b1;
        tick();
        ch3_trig = 1'b0;
        len_tick = 1'b0;
        chk("trig_expire_cnt", 16'(dut.len_cnt_q), 16'h00);
        chk("trig_expire_active", 16'(ch3_active), 16'h1);

        // Reset mid-playback
        ff1e_d = 3'h1;
        ff1d_d = 8'h23;
        ch3_trig = 1'b1;
        tick();
        ch3_trig = 1'b0;
        chk("pre_rst_freq", 16'(freq_cnt), 16'h123);
        chk("pre_rst_active", 16'(ch3_active), 16'h1);
        #1 napu_reset = 1'b0;
        #1;
        chk("midrst_freq", 16'(freq_cnt), 16'h0);
        chk("midrst_active", 16'(ch3_active), 16'h0);
        chk("midrst_out", 16'(ch3_out), 16'h0);
        chk("midrst_rd", 16'(wave_rd), 16'h0);
        chk("midrst_addr", 16'(wave_addr), 16'h0);
        tick(2);
        napu_reset = 1'b1;
        tick(3);
        chk("postrst_active", 16'(ch3_active), 16'h0);
        chk("postrst_freq", 16'(freq_cnt), 16'h0);
        chk("postrst_out", 16'(ch3_out), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
